// File: rtl/cpu_pkg.sv
// Shared widths, requester ids and the issued-command payload for the memory arbiter.
package cpu_pkg;

  localparam int unsigned ADDR_W       = 4;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned MAX_LOCK_DEF = 4;

  typedef enum logic [1:0] {
    REQ_CPU  = 2'd0,
    REQ_HOST = 2'd1,
    REQ_NONE = 2'd2
  } req_id_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  // The requester that is not `id`; REQ_NONE maps to REQ_CPU.
  function automatic req_id_t other_id(input req_id_t id);
    return (id == REQ_CPU) ? REQ_HOST : REQ_CPU;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// One requester's access channel: request/command toward the arbiter, grant/read return back.
interface mem_arbiter_if;
  import cpu_pkg::*;

  logic              req;
  logic              we;
  logic              lock;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational 2-way round-robin picker with lock ownership and a one-shot hand-over override.
module rr_pick
  import cpu_pkg::*;
(
  input  logic [1:0] eligible,
  input  req_id_t    last_winner,
  input  req_id_t    lock_owner,
  input  logic       force_other,
  output req_id_t    winner_c,
  output logic       valid_c
);

  req_id_t pref;
  logic    pref_elig;
  logic    owner_elig;

  always_comb begin
    pref       = other_id(last_winner);
    pref_elig  = (pref == REQ_CPU) ? eligible[0] : eligible[1];
    owner_elig = 1'b0;
    winner_c   = REQ_NONE;
    valid_c    = 1'b0;

    if (lock_owner == REQ_CPU) begin
      owner_elig = eligible[0];
    end else if (lock_owner == REQ_HOST) begin
      owner_elig = eligible[1];
    end

    if (force_other && pref_elig) begin
      winner_c = pref;
      valid_c  = 1'b1;
    end else if (lock_owner != REQ_NONE) begin
      // A held lock blocks the other side even while the owner is idle.
      if (owner_elig) begin
        winner_c = lock_owner;
        valid_c  = 1'b1;
      end
    end else if (&eligible) begin
      winner_c = pref;
      valid_c  = 1'b1;
    end else if (eligible[0]) begin
      winner_c = REQ_CPU;
      valid_c  = 1'b1;
    end else if (eligible[1]) begin
      winner_c = REQ_HOST;
      valid_c  = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous 16x8 memory between CPU and host ports: registered round-robin issue,
// bounded lock for read-modify-write, and a one-cycle read-return pipeline.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.slave      cpu,
  mem_arbiter_if.slave      host,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

  req_id_t          last_winner;
  req_id_t          lock_owner;
  req_id_t          lock_owner_n;
  req_id_t          winner;
  logic [CNT_W-1:0] lock_cnt;
  logic [CNT_W-1:0] lock_cnt_n;
  logic [CNT_W-1:0] cnt_inc;
  logic             force_other;
  logic             force_other_n;
  logic             win_valid;
  logic [1:0]       eligible;
  logic             sel_lock;
  logic             owner_lock;
  logic             owner_req;
  mem_cmd_t         sel_cmd;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] host_rdata_q;

  // A request is already consumed on the edge where its grant is showing.
  assign eligible = {host.req & ~host.gnt, cpu.req & ~cpu.gnt};

  rr_pick u_pick (
    .eligible    (eligible),
    .last_winner (last_winner),
    .lock_owner  (lock_owner),
    .force_other (force_other),
    .winner_c    (winner),
    .valid_c     (win_valid)
  );

  always_comb begin
    sel_cmd    = '{we: cpu.we, addr: cpu.addr, wdata: cpu.wdata};
    sel_lock   = cpu.lock;
    owner_lock = cpu.lock;
    owner_req  = cpu.req;
    if (winner == REQ_HOST) begin
      sel_cmd  = '{we: host.we, addr: host.addr, wdata: host.wdata};
      sel_lock = host.lock;
    end
    if (lock_owner == REQ_HOST) begin
      owner_lock = host.lock;
      owner_req  = host.req;
    end
  end

  // Lock bookkeeping; an owner still holding a pending request keeps the lock until it issues.
  always_comb begin
    lock_owner_n  = lock_owner;
    lock_cnt_n    = lock_cnt;
    force_other_n = 1'b0;
    cnt_inc       = lock_cnt + CNT_W'(1);
    if (win_valid) begin
      if (sel_lock && (cnt_inc == CNT_W'(MAX_LOCK))) begin
        lock_owner_n  = REQ_NONE;
        lock_cnt_n    = '0;
        force_other_n = 1'b1;
      end else if (sel_lock) begin
        lock_owner_n = winner;
        lock_cnt_n   = cnt_inc;
      end else begin
        lock_owner_n = REQ_NONE;
        lock_cnt_n   = '0;
      end
    end else if ((lock_owner != REQ_NONE) && !owner_lock && !owner_req) begin
      lock_owner_n = REQ_NONE;
      lock_cnt_n   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu.gnt      <= 1'b0;
      host.gnt     <= 1'b0;
      cpu.rvalid   <= 1'b0;
      host.rvalid  <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      last_winner  <= REQ_HOST;
      lock_owner   <= REQ_NONE;
      lock_cnt     <= '0;
      force_other  <= 1'b0;
    end else begin
      cpu.gnt     <= win_valid && (winner == REQ_CPU);
      host.gnt    <= win_valid && (winner == REQ_HOST);
      mem_en      <= win_valid;
      mem_we      <= win_valid && sel_cmd.we;
      cpu.rvalid  <= cpu.gnt && !mem_we;
      host.rvalid <= host.gnt && !mem_we;
      lock_owner  <= lock_owner_n;
      lock_cnt    <= lock_cnt_n;
      force_other <= force_other_n;
      if (win_valid) begin
        mem_addr    <= sel_cmd.addr;
        mem_wdata   <= sel_cmd.wdata;
        last_winner <= winner;
      end
      if (cpu.rvalid) begin
        cpu_rdata_q <= mem_rdata;
      end
      if (host.rvalid) begin
        host_rdata_q <= mem_rdata;
      end
    end
  end

  // Memory data arrives in the rvalid cycle; between pulses the last word is held.
  assign cpu.rdata  = cpu.rvalid  ? mem_rdata : cpu_rdata_q;
  assign host.rdata = host.rvalid ? mem_rdata : host_rdata_q;

  gnt_onehot: assert property (@(posedge clk) disable iff (rst) !(cpu.gnt && host.gnt));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 16x8 synchronous memory.
module tb_mem_arbiter;
  import cpu_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = 8'h00;
  logic [DATA_W-1:0] mem [16] = '{8'h00, 8'h11, 8'h22, 8'hA5, 8'h00, 8'h21, 8'h00, 8'h77,
                                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter_if cpu_if ();
  mem_arbiter_if host_if ();

  mem_arbiter #(.MAX_LOCK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu       (cpu_if),
    .host      (host_if),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_cpu(input logic req, input logic we, input logic lock,
                           input logic [3:0] addr, input logic [7:0] wdata);
    cpu_if.req = req; cpu_if.we = we; cpu_if.lock = lock;
    cpu_if.addr = addr; cpu_if.wdata = wdata;
  endtask

  task automatic drive_host(input logic req, input logic we, input logic lock,
                            input logic [3:0] addr, input logic [7:0] wdata);
    host_if.req = req; host_if.we = we; host_if.lock = lock;
    host_if.addr = addr; host_if.wdata = wdata;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cpu_gnt"},    8'(cpu_if.gnt),     8'h00);
    check({tag, "_host_gnt"},   8'(host_if.gnt),    8'h00);
    check({tag, "_cpu_rvalid"}, 8'(cpu_if.rvalid),  8'h00);
    check({tag, "_host_rvalid"},8'(host_if.rvalid), 8'h00);
    check({tag, "_mem_en"},     8'(mem_en),         8'h00);
  endtask

  logic        e_cg;
  logic [7:0]  e_addr;
  logic [10:0] exp_cpu_f;
  logic [10:0] exp_host_f;

  initial begin
    rst = 1'b1;
    drive_cpu(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    drive_host(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);

    // Power-on reset
    step(); step();
    check_idle("rst0");
    check("rst0_mem_addr", 8'(mem_addr), 8'h00);
    check("rst0_cpu_rdata", cpu_if.rdata, 8'h00);
    rst = 1'b0;

    // Both request continuously: C,H,C,H with reads routed back
    drive_cpu(1'b1, 1'b0, 1'b0, 4'h1, 8'h00);
    drive_host(1'b1, 1'b0, 1'b0, 4'h2, 8'h00);
    for (int i = 1; i <= 4; i++) begin
      step();
      e_cg   = (i % 2) == 1;
      e_addr = e_cg ? 8'h01 : 8'h02;
      check("alt_cpu_gnt", 8'(cpu_if.gnt), 8'(e_cg));
      check("alt_host_gnt", 8'(host_if.gnt), 8'(!e_cg));
      check("alt_mem_addr", 8'(mem_addr), e_addr);
      check("alt_cpu_rvalid", 8'(cpu_if.rvalid), 8'(!e_cg));
      check("alt_host_rvalid", 8'(host_if.rvalid), 8'(i == 3));
      if (!e_cg) check("alt_cpu_rdata", cpu_if.rdata, 8'h11);
      if (i == 3) check("alt_host_rdata", host_if.rdata, 8'h22);
    end
    drive_cpu(1'b0, 1'b0, 1'b0, 4'h1, 8'h00);
    drive_host(1'b0, 1'b0, 1'b0, 4'h2, 8'h00);
    step(); step(); step();

    // Reset mid-traffic after a CPU grant; first tie afterwards must go to CPU
    drive_cpu(1'b1, 1'b0, 1'b0, 4'h1, 8'h00);
    step();
    check("rstc_pre_cpu_gnt", 8'(cpu_if.gnt), 8'h01);
    rst = 1'b1;
    drive_cpu(1'b0, 1'b0, 1'b0, 4'h1, 8'h00);
    drive_host(1'b1, 1'b0, 1'b0, 4'h2, 8'h00);
    step();
    check_idle("rstc1");
    step();
    check_idle("rstc2");
    rst = 1'b0;
    drive_cpu(1'b1, 1'b0, 1'b0, 4'h1, 8'h00);
    step();
    check("rstc_tie_cpu_gnt", 8'(cpu_if.gnt), 8'h01);
    check("rstc_tie_host_gnt", 8'(host_if.gnt), 8'h00);
    drive_cpu(1'b0, 1'b0, 1'b0, 4'h1, 8'h00);
    step();
    check("rstc_next_host_gnt", 8'(host_if.gnt), 8'h01);
    drive_host(1'b0, 1'b0, 1'b0, 4'h2, 8'h00);
    step(); step(); step();

    // Single CPU read of addr 3
    drive_cpu(1'b1, 1'b0, 1'b0, 4'h3, 8'h00);
    step();
    check("rd_cpu_gnt", 8'(cpu_if.gnt), 8'h01);
    check("rd_host_gnt", 8'(host_if.gnt), 8'h00);
    check("rd_mem_en", 8'(mem_en), 8'h01);
    check("rd_mem_we", 8'(mem_we), 8'h00);
    check("rd_mem_addr", 8'(mem_addr), 8'h03);
    drive_cpu(1'b0, 1'b0, 1'b0, 4'h3, 8'h00);
    step();
    check("rd_cpu_rvalid", 8'(cpu_if.rvalid), 8'h01);
    check("rd_cpu_rdata", cpu_if.rdata, 8'hA5);
    check("rd_host_rvalid", 8'(host_if.rvalid), 8'h00);
    check("rd_cpu_gnt_pulse", 8'(cpu_if.gnt), 8'h00);
    step();
    check("rd_cpu_rvalid_pulse", 8'(cpu_if.rvalid), 8'h00);
    check("rd_cpu_rdata_hold", cpu_if.rdata, 8'hA5);

    // Locked read-modify-write on addr 5 while host keeps requesting
    drive_cpu(1'b1, 1'b0, 1'b1, 4'h5, 8'h00);
    step();
    check("rmw_rd_gnt", 8'(cpu_if.gnt), 8'h01);
    check("rmw_rd_addr", 8'(mem_addr), 8'h05);
    drive_cpu(1'b0, 1'b0, 1'b1, 4'h5, 8'h00);
    drive_host(1'b1, 1'b0, 1'b0, 4'h2, 8'h00);
    step();
    check("rmw_rvalid", 8'(cpu_if.rvalid), 8'h01);
    check("rmw_rdata", cpu_if.rdata, 8'h21);
    check("rmw_host_blocked", 8'(host_if.gnt), 8'h00);
    drive_cpu(1'b1, 1'b1, 1'b0, 4'h5, 8'h42);
    step();
    check("rmw_wr_gnt", 8'(cpu_if.gnt), 8'h01);
    check("rmw_wr_host_blocked", 8'(host_if.gnt), 8'h00);
    check("rmw_wr_mem_we", 8'(mem_we), 8'h01);
    check("rmw_wr_wdata", mem_wdata, 8'h42);
    check("rmw_wr_addr", 8'(mem_addr), 8'h05);
    drive_cpu(1'b0, 1'b0, 1'b0, 4'h5, 8'h00);
    step();
    check("rmw_host_gnt", 8'(host_if.gnt), 8'h01);
    check("rmw_host_addr", 8'(mem_addr), 8'h02);
    check("rmw_wr_no_rvalid", 8'(cpu_if.rvalid), 8'h00);
    drive_host(1'b0, 1'b0, 1'b0, 4'h2, 8'h00);
    step(); step();
    check("rmw_mem5", mem[5], 8'h42);

    // Lock starvation guard: host gets in right after the 4th locked CPU grant
    exp_cpu_f  = 11'b101_0101_0101;
    exp_host_f = 11'b000_1000_0000;
    drive_cpu(1'b1, 1'b0, 1'b1, 4'h7, 8'h00);
    drive_host(1'b1, 1'b0, 1'b0, 4'h2, 8'h00);
    for (int k = 1; k <= 11; k++) begin
      step();
      check("starve_cpu_gnt", 8'(cpu_if.gnt), 8'(exp_cpu_f[4'(k - 1)]));
      check("starve_host_gnt", 8'(host_if.gnt), 8'(exp_host_f[4'(k - 1)]));
      if (k == 8)  drive_host(1'b0, 1'b0, 1'b0, 4'h2, 8'h00);
      if (k == 11) drive_cpu(1'b0, 1'b0, 1'b0, 4'h7, 8'h00);
    end
    step(); step(); step();

    // Reset while a host read is in flight
    drive_host(1'b1, 1'b0, 1'b0, 4'h2, 8'h00);
    step();
    check("rstm_host_gnt", 8'(host_if.gnt), 8'h01);
    rst = 1'b1;
    drive_host(1'b0, 1'b0, 1'b0, 4'h2, 8'h00);
    step();
    check_idle("rstm1");
    rst = 1'b0;
    step();
    check("rstm_no_rvalid", 8'(host_if.rvalid), 8'h00);
    drive_cpu(1'b1, 1'b0, 1'b0, 4'h1, 8'h00);
    drive_host(1'b1, 1'b0, 1'b0, 4'h2, 8'h00);
    step();
    check("rstm_tie_cpu_gnt", 8'(cpu_if.gnt), 8'h01);
    check("rstm_tie_host_gnt", 8'(host_if.gnt), 8'h00);
    drive_cpu(1'b0, 1'b0, 1'b0, 4'h1, 8'h00);
    step();
    check("rstm_host_gnt2", 8'(host_if.gnt), 8'h01);
    check("rstm_cpu_rvalid", 8'(cpu_if.rvalid), 8'h01);
    check("rstm_cpu_rdata", cpu_if.rdata, 8'h11);
    drive_host(1'b0, 1'b0, 1'b0, 4'h2, 8'h00);
    step();
    check("rstm_host_rvalid", 8'(host_if.rvalid), 8'h01);
    check("rstm_host_rdata", host_if.rdata, 8'h22);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
